pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// Instruction-pointer sequencer with a bounded return-address stack and taken-transfer counter.
// Latency: ip, depth, jump_cnt, halted and fault all update one cycle after the op is presented with en=1.
// Backpressure: none; en=0 stalls in RUN, while HALT and FAULT ignore all inputs until rst.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   en, op, target, cond     instruction strobe, opcode (NEXT/JUMP/BRANCH/CALL/RET), destination, branch condition
//   ip                       registered instruction pointer
//   halted, fault            HALT state flag; fault code (01 overflow, 10 underflow, 11 illegal op)
//   depth, jump_cnt          stack occupancy; saturating count of taken non-sequential transfers
module pc_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int STACK_DEPTH = 4,
    parameter int CNT_W       = 8,
    parameter int RESET_PC    = 0,
    localparam int DEPTH_W    = $clog2(STACK_DEPTH + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [2:0]         op,
    input  logic [ADDR_W-1:0]  target,
    input  logic               cond,
    output logic [ADDR_W-1:0]  ip,
    output logic               halted,
    output logic [1:0]         fault,
    output logic [DEPTH_W-1:0] depth,
    output logic [CNT_W-1:0]   jump_cnt
);

    localparam logic [2:0] OP_NEXT   = 3'b000;
    localparam logic [2:0] OP_JUMP   = 3'b001;
    localparam logic [2:0] OP_BRANCH = 3'b010;
    localparam logic [2:0] OP_CALL   = 3'b011;
    localparam logic [2:0] OP_RET    = 3'b100;

    localparam logic [1:0] FLT_NONE  = 2'b00;
    localparam logic [1:0] FLT_OVF   = 2'b01;
    localparam logic [1:0] FLT_UNF   = 2'b10;
    localparam logic [1:0] FLT_ILL   = 2'b11;

    localparam logic [DEPTH_W-1:0] FULL_DEPTH = DEPTH_W'(STACK_DEPTH);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};
    localparam int                 STACK_SLOTS = 1 << DEPTH_W;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ip_q, ip_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          fault_q, fault_d;
    logic                push;
    logic                taken;

    // Sized to the full index range of depth so push/pop addressing needs no
    // truncation; slots at or above STACK_DEPTH are never written.
    logic [ADDR_W-1:0]   stack_q [STACK_SLOTS];

    logic [ADDR_W-1:0]   ip_inc;
    logic [DEPTH_W-1:0]  top_idx;

    assign ip_inc  = ip_q + ADDR_W'(1);   // wraps silently at all-ones
    assign top_idx = depth_q - DEPTH_W'(1);

    always_comb begin
        state_d = state_q;
        ip_d    = ip_q;
        depth_d = depth_q;
        fault_d = fault_q;
        push    = 1'b0;
        taken   = 1'b0;

        if (state_q == ST_RUN && en) begin
            case (op)
                OP_NEXT: ip_d = ip_inc;
                OP_JUMP, OP_BRANCH: begin
                    if (op == OP_JUMP || cond) begin
                        taken = 1'b1;
                        ip_d  = target;
                        // A taken transfer onto itself can never make progress.
                        if (target == ip_q) state_d = ST_HALT;
                    end else begin
                        ip_d = ip_inc;
                    end
                end
                OP_CALL: begin
                    if (depth_q == FULL_DEPTH) begin
                        fault_d = FLT_OVF;
                        state_d = ST_FAULT;
                    end else begin
                        push    = 1'b1;
                        taken   = 1'b1;
                        ip_d    = target;
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end
                OP_RET: begin
                    if (depth_q == '0) begin
                        fault_d = FLT_UNF;
                        state_d = ST_FAULT;
                    end else begin
                        taken   = 1'b1;
                        ip_d    = stack_q[top_idx];
                        depth_d = top_idx;
                    end
                end
                default: begin
                    fault_d = FLT_ILL;
                    state_d = ST_FAULT;
                end
            endcase
        end

        cnt_d = (taken && cnt_q != CNT_MAX) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            ip_q    <= ADDR_W'(RESET_PC);
            depth_q <= '0;
            cnt_q   <= '0;
            fault_q <= FLT_NONE;
        end else begin
            state_q <= state_d;
            ip_q    <= ip_d;
            depth_q <= depth_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    // Return addresses are left uncleared by reset; depth alone defines validity.
    always_ff @(posedge clk) begin
        if (push && !rst) stack_q[depth_q] <= ip_inc;
    end

    assign ip       = ip_q;
    assign halted   = (state_q == ST_HALT);
    assign fault    = fault_q;
    assign depth    = depth_q;
    assign jump_cnt = cnt_q;

endmodule
